// File: rtl/mem_stage.sv
// Memory pipeline stage: word loads/stores over a req/ack port, branch redirect,
// condition-code register and write-back generation with upstream stall.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_branch,
  input  logic [DATA_W-1:0] ex_new_pc,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_set_cond,
  input  logic [1:0]        ex_cv,
  output logic              stall,
  output logic [3:0]        alu_cond,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              align_err,
  output logic              bus_err
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, we_q;
  logic [DATA_W-1:0]   addr_q, wdata_q;
  logic [RD_W-1:0]     rd_q;
  logic                wb_valid_q, wb_we_q;
  logic [RD_W-1:0]     wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                redir_valid_q;
  logic [DATA_W-1:0]   redir_pc_q;
  logic                align_err_q, bus_err_q;
  logic [3:0]          cond_q;

  logic accept, mem_op, bad_op;

  assign stall  = (state_q != S_IDLE);
  assign accept = ex_valid && !stall;
  assign mem_op = ex_mem_read || ex_mem_write;
  assign bad_op = (ex_alu_result[1:0] != 2'b00) || (ex_mem_read && ex_mem_write);
  assign cnt_d  = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      align_err_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      cond_q        <= '0;
    end else begin
      wb_valid_q    <= 1'b0;
      redir_valid_q <= 1'b0;
      align_err_q   <= 1'b0;

      if (accept && ex_set_cond)
        cond_q <= {ex_alu_result[DATA_W-1], ex_alu_result == '0, ex_cv};

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wb_rd_q <= ex_rd;
            // A branch suppresses any memory op and never writes rd.
            if (ex_branch || !mem_op) begin
              wb_valid_q    <= 1'b1;
              wb_we_q       <= (ex_rd != '0) && !ex_branch;
              wb_data_q     <= ex_alu_result;
              redir_valid_q <= ex_branch;
              if (ex_branch)
                redir_pc_q <= ex_new_pc;
            end else if (bad_op) begin
              align_err_q <= 1'b1;
              wb_valid_q  <= 1'b1;
              wb_we_q     <= 1'b0;
              wb_data_q   <= ex_alu_result;
            end else begin
              req_q   <= 1'b1;
              we_q    <= ex_mem_write;
              addr_q  <= ex_alu_result;
              wdata_q <= ex_store_data;
              rd_q    <= ex_rd;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Ack wins over a timeout reached in the same cycle.
          if (dmem_ack) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_we_q    <= !we_q && (rd_q != '0);
            if (!we_q)
              wb_data_q <= dmem_rdata;
            state_q    <= S_IDLE;
          end else if (cnt_d == TIMEOUT_C) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            bus_err_q  <= 1'b1;
            wb_valid_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= rd_q;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_cond       = cond_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_we          = wb_we_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign align_err      = align_err_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-scenario tasks with inline checks plus a write-back
// scoreboard filled when stimulus is driven and drained by a negedge monitor.
module tb_mem_stage;

  logic        clk, rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result, ex_store_data, ex_new_pc;
  logic [5:0]  ex_rd;
  logic        ex_branch, ex_mem_read, ex_mem_write, ex_set_cond;
  logic [1:0]  ex_cv;
  logic        stall;
  logic [3:0]  alu_cond;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        align_err, bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [5:0]  rd;
    logic [31:0] data;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];

  mem_stage #(.DATA_W(32), .RD_W(6), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_branch(ex_branch),
    .ex_new_pc(ex_new_pc), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_set_cond(ex_set_cond), .ex_cv(ex_cv), .stall(stall), .alu_cond(alu_cond),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got wb_valid with rd=%0d data=%h, required no write-back", wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        if (wb_we !== e.we || wb_rd !== e.rd || (e.chk_data && wb_data !== e.data)) begin
          errors++;
          $display("FAIL wb_entry: got we=%b rd=%0d data=%h, required we=%b rd=%0d data=%h",
                   wb_we, wb_rd, wb_data, e.we, e.rd, e.data);
        end
      end
    end
  end

  function automatic wb_exp_t mk(input logic we, input logic [5:0] rd,
                                 input logic [31:0] data, input logic chk);
    wb_exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.chk_data = chk;
    return e;
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_new_pc = '0;
    ex_rd = '0; ex_branch = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_set_cond = 0; ex_cv = '0;
  endtask

  // Present one instruction for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input logic rd_op, input logic wr_op, input logic br,
                       input logic sc, input logic [31:0] res, input logic [31:0] sd,
                       input logic [31:0] npc, input logic [5:0] rd, input logic [1:0] cv);
    @(negedge clk);
    ex_valid = 1; ex_mem_read = rd_op; ex_mem_write = wr_op; ex_branch = br;
    ex_set_cond = sc; ex_alu_result = res; ex_store_data = sd; ex_new_pc = npc;
    ex_rd = rd; ex_cv = cv;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    dmem_ack = 0; dmem_rdata = '0;
    #2;
    checks++;
    if ({stall, dmem_req, dmem_we, wb_valid, wb_we, redirect_valid, align_err, bus_err, alu_cond} !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {stall, dmem_req, dmem_we, wb_valid, wb_we, redirect_valid, align_err, bus_err, alu_cond});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_alu();
    logic [31:0] r;
    sb.push_back(mk(1'b1, 6'd3, 32'hA5, 1'b1));
    issue(0, 0, 0, 0, 32'h0000_00A5, 0, 0, 6'd3, 2'b00);
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency: got stall=%b wb_valid=%b, required 0 and 1", stall, wb_valid);
    end
    sb.push_back(mk(1'b0, 6'd0, 32'h55, 1'b1));
    issue(0, 0, 0, 0, 32'h55, 0, 0, 6'd0, 2'b00);
    r = 32'h8000_0000;
    sb.push_back(mk(1'b1, 6'd12, r, 1'b1));
    issue(0, 0, 0, 1, r, 0, 0, 6'd12, 2'b10);
    checks++;
    if (alu_cond !== {r[31], r == 0, 2'b10}) begin
      errors++;
      $display("FAIL alu_cond_neg: got %b, required %b", alu_cond, {r[31], r == 0, 2'b10});
    end
  endtask

  task automatic test_load();
    sb.push_back(mk(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b1));
    issue(1, 0, 0, 0, 32'h100, 0, 0, 6'd5, 2'b00);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stall !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin
        errors++;
        $display("FAIL load_wait[%0d]: got stall=%b req=%b we=%b addr=%h, required 1 1 0 00000100",
                 i, stall, dmem_req, dmem_we, dmem_addr);
      end
      if (i == 3) begin dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    dmem_ack = 0; dmem_rdata = '0;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_done: got stall=%b req=%b wb_valid=%b, required 0 0 1", stall, dmem_req, wb_valid);
    end
  endtask

  task automatic test_store();
    sb.push_back(mk(1'b0, 6'd2, 32'h0, 1'b0));
    issue(0, 1, 0, 0, 32'h104, 32'h1234, 0, 6'd2, 2'b00);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h104 || dmem_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h, required 1 1 00000104 00001234",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL store_done: got req=%b stall=%b wb_valid=%b, required 0 0 1", dmem_req, stall, wb_valid);
    end
  endtask

  task automatic test_misalign();
    sb.push_back(mk(1'b0, 6'd4, 32'h0, 1'b0));
    issue(1, 0, 0, 0, 32'h102, 0, 0, 6'd4, 2'b00);
    checks++;
    if (dmem_req !== 1'b0 || align_err !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign: got req=%b align_err=%b stall=%b, required 0 1 0", dmem_req, align_err, stall);
    end
    @(negedge clk);
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_pulse: got align_err=%b, required 0", align_err);
    end
    sb.push_back(mk(1'b0, 6'd1, 32'h0, 1'b0));
    issue(1, 1, 0, 0, 32'h108, 32'h9, 0, 6'd1, 2'b00);
    checks++;
    if (dmem_req !== 1'b0 || align_err !== 1'b1) begin
      errors++;
      $display("FAIL rw_both: got req=%b align_err=%b, required 0 1", dmem_req, align_err);
    end
  endtask

  task automatic test_timeout();
    sb.push_back(mk(1'b0, 6'd7, 32'h0, 1'b0));
    issue(1, 0, 0, 0, 32'h200, 0, 0, 6'd7, 2'b00);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dmem_req !== 1'b1 || bus_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: got req=%b bus_err=%b, required 1 0", i, dmem_req, bus_err);
      end
      @(negedge clk);
    end
    checks++;
    if (dmem_req !== 1'b0 || bus_err !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit: got req=%b bus_err=%b stall=%b wb_valid=%b, required 0 1 0 1",
               dmem_req, bus_err, stall, wb_valid);
    end
    sb.push_back(mk(1'b1, 6'd8, 32'h11, 1'b1));
    issue(0, 0, 0, 0, 32'h11, 0, 0, 6'd8, 2'b00);
    repeat (3) @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin
      errors++;
      $display("FAIL bus_err_sticky: got %b, required 1", bus_err);
    end
  endtask

  task automatic test_branch();
    sb.push_back(mk(1'b0, 6'd9, 32'h0, 1'b1));
    issue(1, 0, 1, 1, 32'h0, 0, 32'h40, 6'd9, 2'b01);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40 || alu_cond !== 4'b0101 ||
        dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL branch: got rv=%b pc=%h cond=%b req=%b stall=%b, required 1 00000040 0101 0 0",
               redirect_valid, redirect_pc, alu_cond, dmem_req, stall);
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b0 || alu_cond !== 4'b0101) begin
      errors++;
      $display("FAIL branch_pulse: got rv=%b cond=%b, required 0 0101", redirect_valid, alu_cond);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_valid = 1; ex_alu_result = 32'h21; ex_rd = 6'd21;
    sb.push_back(mk(1'b1, 6'd21, 32'h21, 1'b1));
    @(negedge clk);
    ex_alu_result = 32'h22; ex_rd = 6'd22;
    sb.push_back(mk(1'b1, 6'd22, 32'h22, 1'b1));
    @(negedge clk);
    ex_mem_read = 1; ex_alu_result = 32'h300; ex_rd = 6'd23;
    sb.push_back(mk(1'b1, 6'd23, 32'hCAFE_0001, 1'b1));
    @(negedge clk);
    // Stalled: the held ALU op must wait until the load completes.
    ex_mem_read = 0; ex_alu_result = 32'h77; ex_rd = 6'd11;
    dmem_ack = 1; dmem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    dmem_ack = 0; dmem_rdata = '0;
    sb.push_back(mk(1'b1, 6'd11, 32'h77, 1'b1));
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending write-backs, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(1, 0, 0, 0, 32'h400, 0, 0, 6'd6, 2'b00);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got req=%b, required 1", dmem_req);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dmem_req, stall, wb_valid, redirect_valid, align_err, bus_err, alu_cond} !== 10'h0) begin
      errors++;
      $display("FAIL rst_mid_wait: got %b, required all zero",
               {dmem_req, stall, wb_valid, redirect_valid, align_err, bus_err, alu_cond});
    end
    @(negedge clk);
    rst_n = 1;
    sb.push_back(mk(1'b1, 6'd13, 32'h1357, 1'b1));
    issue(0, 0, 0, 0, 32'h1357, 0, 0, 6'd13, 2'b00);
    checks++;
    if (wb_valid !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: got wb_valid=%b stall=%b req=%b, required 1 0 0", wb_valid, stall, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_branch();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending write-backs, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the registered execute results: ALU result or address, store data, destination register, branch flag and target PC.
- Performs word loads and stores over a req/ack data-memory port, resolves branch redirects and holds the condition-code register that feeds back to execute as alu_cond.
- Drives the write-back interface and stalls upstream while a memory access is outstanding.

Parameters:
DATA_W, 32, data/address width
RD_W, 6, destination register index width
TIMEOUT, 15, max cycles waiting for dmem_ack before bus error (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute latch holds a valid instruction
ex_alu_result  in  DATA_W  ALU result, or effective address for load/store
ex_store_data  in  DATA_W  store data (execute dataB)
ex_rd  in  RD_W  destination register
ex_branch  in  1  branch taken
ex_new_pc  in  DATA_W  branch target
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_set_cond  in  1  update condition codes
ex_cv  in  2  {C,V} flags from ALU
stall  out  1  upstream must hold its latch
alu_cond  out  4  condition register {N,Z,C,V} to execute
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  DATA_W  word address (byte address, [1:0]=0)
dmem_wdata  out  DATA_W  write data
dmem_ack  in  1  memory completed request
dmem_rdata  in  DATA_W  read data, valid with ack
wb_valid  out  1  write-back entry valid (1-cycle pulse)
wb_we  out  1  register-file write enable
wb_rd  out  RD_W  write-back register
wb_data  out  DATA_W  write-back data
redirect_valid  out  1  branch redirect pulse
redirect_pc  out  DATA_W  redirect target
align_err  out  1  1-cycle pulse: misaligned or illegal memory op
bus_err  out  1  sticky: ack timeout occurred

Behaviour:
- Reset: every output is 0, state = IDLE, alu_cond = 4'b0, bus_err cleared. Reset is asynchronous. Asserting it mid-WAIT drops dmem_req immediately and abandons the access.
- stall = (state != IDLE), combinational from state. An instruction is accepted when ex_valid && !stall. ex_valid while stalled is ignored; upstream holds its values.
- FSM states are IDLE and WAIT.
- IDLE, accepted instruction with no memory op:
  - next cycle wb_valid = 1, wb_data = ex_alu_result, wb_rd = ex_rd.
  - wb_we = (ex_rd != 0) && !ex_branch.
  - Latency is 1 cycle.
- IDLE, accepted load or store with ex_alu_result[1:0] == 0 and not both read and write:
  - capture address and data.
  - next cycle dmem_req = 1 and dmem_we = ex_mem_write.
  - go to WAIT and clear the timeout counter.
- IDLE, accepted memory op with address[1:0] != 0, or with read and write both set:
  - no request is issued.
  - next cycle align_err = 1 and wb_valid = 1 with wb_we = 0.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until dmem_ack is sampled high.
  - On ack: dmem_req = 0 next cycle and wb_valid = 1. A load gives wb_data = dmem_rdata and wb_we = (rd != 0). A store gives wb_we = 0. Return to IDLE; a new instruction may be accepted that same cycle.
  - Counter increments each WAIT cycle without ack. When it reaches TIMEOUT: drop dmem_req, set bus_err (sticky), pulse wb_valid with wb_we = 0, return to IDLE.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
- Load timing: accepted in cycle T, dmem_req high from T+1, ack at T+k, wb_valid in T+k+1.
- Branch: an accepted ex_branch gives, next cycle, redirect_valid = 1 (one cycle) and redirect_pc = ex_new_pc. A branch never writes rd. Branch combined with a memory op: the memory op is ignored and treated as a plain branch.
- Condition codes: on accept with ex_set_cond, alu_cond <= {ex_alu_result[DATA_W-1], ex_alu_result == 0, ex_cv}. This is visible the cycle after acceptance. Otherwise alu_cond holds.
- wb_valid, redirect_valid and align_err are single-cycle pulses. wb_data and wb_rd hold their last value when wb_valid = 0.

Test Plan:
- Reset release, then ALU op: ex_alu_result=0x0000_00A5, ex_rd=3 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=0xA5, stall=0.
- Load at 0x100, ack held off 3 cycles, rdata=0xDEAD_BEEF -> stall high 4 cycles, dmem_addr stable at 0x100, wb_data=0xDEADBEEF one cycle after ack.
- Store at 0x104 with data 0x1234, ack in the first WAIT cycle -> dmem_we=1, dmem_wdata=0x1234, wb_valid=1 with wb_we=0.
- Load at 0x102 -> no dmem_req, align_err pulse, wb_we=0. Then no ack for TIMEOUT=15 cycles on a load -> req drops, bus_err=1 and stays 1.
- Branch with ex_new_pc=0x40 and ex_set_cond=1, result=0, cv=2'b01 -> redirect_valid pulse with redirect_pc=0x40, alu_cond=4'b0101, wb_we=0.
- rst_n low during WAIT -> dmem_req, stall and all outputs go to 0 immediately, and the next accepted instruction behaves normally.
